button_conditioner: RTL and testbench



---
 rtl/button_conditioner_pkg.sv | 22 ++
 rtl/button_conditioner_debounce_channel.sv | 114 +++++++++++
 rtl/button_conditioner.sv | 51 +++++
 tb/tb_button_conditioner.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared button indices, default timing constants and the per-channel repeat FSM state type.
package button_conditioner_pkg;

  localparam int unsigned BTN_D    = 0;
  localparam int unsigned BTN_C    = 1;
  localparam int unsigned BTN_U    = 2;
  localparam int unsigned BTN_L    = 3;
  localparam int unsigned BTN_R    = 4;
  localparam int unsigned NUM_BTNS = 5;
  localparam int unsigned NUM_SW   = 16;

  localparam int unsigned DEBOUNCE_CYCLES = 650000;
  localparam int unsigned REPEAT_DELAY    = 26000000;
  localparam int unsigned REPEAT_PERIOD   = 6500000;

  typedef enum logic [1:0] {RptIdle, RptDelay, RptRepeat} rpt_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// One button: two-flop synchroniser, debounce counter and auto-repeat FSM.
module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = button_conditioner_pkg::DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = button_conditioner_pkg::REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = button_conditioner_pkg::REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rpt
);

  localparam int unsigned DCW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RCW = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);

  logic [1:0]     sync_q;
  logic [DCW-1:0] dcnt_q, dcnt_d;
  logic           level_q, level_d;
  logic           press_q, press_d;
  logic           rpt_q, rpt_d;
  logic [RCW-1:0] rcnt_q, rcnt_d;
  rpt_state_e     state_q, state_d;
  logic           rise, fall;

  always_comb begin
    dcnt_d  = dcnt_q;
    level_d = level_q;
    rise    = 1'b0;
    fall    = 1'b0;
    if (sync_q[1] == level_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == DCW'(DEBOUNCE_CYCLES - 1)) begin
      level_d = ~level_q;
      dcnt_d  = '0;
      rise    = ~level_q;
      fall    = level_q;
    end else begin
      dcnt_d = dcnt_q + 1'b1;
    end
    press_d = rise;
  end

  // An accepted fall wins over a repeat pulse due in the same cycle.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    rpt_d   = 1'b0;
    unique case (state_q)
      RptIdle: begin
        if (rise) begin
          rpt_d   = 1'b1;
          state_d = RptDelay;
          rcnt_d  = '0;
        end
      end
      RptDelay: begin
        if (fall) begin
          state_d = RptIdle;
          rcnt_d  = '0;
        end else if (rcnt_q == RCW'(REPEAT_DELAY - 1)) begin
          rpt_d   = 1'b1;
          state_d = RptRepeat;
          rcnt_d  = '0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      RptRepeat: begin
        if (fall) begin
          state_d = RptIdle;
          rcnt_d  = '0;
        end else if (rcnt_q == RCW'(REPEAT_PERIOD - 1)) begin
          rpt_d  = 1'b1;
          rcnt_d = '0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RptIdle;
        rcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      dcnt_q  <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rpt_q   <= 1'b0;
      rcnt_q  <= '0;
      state_q <= RptIdle;
    end else begin
      sync_q  <= {sync_q[0], raw};
      dcnt_q  <= dcnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rpt_q   <= rpt_d;
      rcnt_q  <= rcnt_d;
      state_q <= state_d;
    end
  end

  assign level = level_q;
  assign press = press_q;
  assign rpt   = rpt_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions raw board buttons (debounce, press and repeat pulses) and synchronises switches.
module button_conditioner #(
  parameter int unsigned NUM_BTNS        = button_conditioner_pkg::NUM_BTNS,
  parameter int unsigned NUM_SW          = button_conditioner_pkg::NUM_SW,
  parameter int unsigned DEBOUNCE_CYCLES = button_conditioner_pkg::DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = button_conditioner_pkg::REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = button_conditioner_pkg::REPEAT_PERIOD
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [NUM_BTNS-1:0] btn_in,
  input  logic [NUM_SW-1:0]   sw_in,
  output logic [NUM_BTNS-1:0] btn_level_out,
  output logic [NUM_BTNS-1:0] btn_press_out,
  output logic [NUM_BTNS-1:0] btn_repeat_out,
  output logic [NUM_SW-1:0]   sw_out
);

  import button_conditioner_pkg::*;

  logic [NUM_SW-1:0] sw_meta_q, sw_sync_q;

  // Switches are only synchronised; they are not debounced.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= sw_in;
      sw_sync_q <= sw_meta_q;
    end
  end

  assign sw_out = sw_sync_q;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_chan (
      .clk  (clk_in),
      .rst  (rst_in),
      .raw  (btn_in[i]),
      .level(btn_level_out[i]),
      .press(btn_press_out[i]),
      .rpt  (btn_repeat_out[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/repeat timing.
module tb_button_conditioner;

  localparam int unsigned NB = 5;
  localparam int unsigned NS = 16;
  localparam int unsigned DC = 4;
  localparam int unsigned RD = 10;
  localparam int unsigned RP = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btn;
  logic [NS-1:0] sw;
  logic [NB-1:0] lvl, prs, rpt;
  logic [NS-1:0] swo;

  int total = 0;
  int bad   = 0;

  button_conditioner #(
    .NUM_BTNS       (NB),
    .NUM_SW         (NS),
    .DEBOUNCE_CYCLES(DC),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .btn_in        (btn),
    .sw_in         (sw),
    .btn_level_out (lvl),
    .btn_press_out (prs),
    .btn_repeat_out(rpt),
    .sw_out        (swo)
  );

  always #5 clk = ~clk;

  // Advance one edge and sample just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn = '0;
    sw  = '0;
    #2;
    total++;
    if ({lvl, prs, rpt, swo} !== '0) begin
      bad++;
      $display("FAIL reset_state got=%h exp=0", {lvl, prs, rpt, swo});
    end
    step();
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) step();
  endtask

  // Edge k counts from the edge at which the input was driven (k=1 is the next edge).
  task automatic test_clean_press();
    logic [NB-1:0] el, ep, er;
    btn[2] = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      step();
      el = '0; ep = '0; er = '0;
      el[2] = (k >= 6) && (k < 36);
      ep[2] = (k == 6);
      er[2] = (k == 6) || ((k >= 16) && (k < 36) && ((k - 16) % 3 == 0));
      total++;
      if ({lvl, prs, rpt} !== {el, ep, er}) begin
        bad++;
        $display("FAIL clean_press k=%0d got=%b/%b/%b exp=%b/%b/%b", k, lvl, prs, rpt,
                 el, ep, er);
      end
      if (k == 30) btn[2] = 1'b0;
    end
  endtask

  task automatic test_bounce();
    logic [15:0] pat;
    pat = 16'b0000_0000_1110_0111;  // LSB first: high 3, low 2, high 3, low
    for (int k = 0; k < 20; k++) begin
      btn[0] = pat[k[3:0]];
      step();
      total++;
      if ({lvl, prs, rpt} !== '0) begin
        bad++;
        $display("FAIL bounce k=%0d got=%b/%b/%b exp=0/0/0", k, lvl, prs, rpt);
      end
    end
    btn[0] = 1'b0;
  endtask

  task automatic test_release_in_delay();
    logic [NB-1:0] el, ep, er;
    btn[1] = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      step();
      el = '0; ep = '0; er = '0;
      el[1] = (k >= 6) && (k < 14);
      ep[1] = (k == 6);
      er[1] = (k == 6);
      total++;
      if ({lvl, prs, rpt} !== {el, ep, er}) begin
        bad++;
        $display("FAIL release_delay k=%0d got=%b/%b/%b exp=%b/%b/%b", k, lvl, prs, rpt,
                 el, ep, er);
      end
      if (k == 8) btn[1] = 1'b0;
    end
  endtask

  task automatic test_simultaneous();
    logic e_l, e_p, e_r;
    btn[4:3] = 2'b11;
    for (int k = 1; k <= 30; k++) begin
      step();
      e_l = (k >= 6) && (k < 26);
      e_p = (k == 6);
      e_r = (k == 6) || ((k >= 16) && (k < 26) && ((k - 16) % 3 == 0));
      total++;
      if ({lvl, prs, rpt} !== {e_l, e_l, 3'b000, e_p, e_p, 3'b000, e_r, e_r, 3'b000}) begin
        bad++;
        $display("FAIL simultaneous k=%0d got=%b/%b/%b exp_bit=%b/%b/%b", k, lvl, prs, rpt,
                 e_l, e_p, e_r);
      end
      if (k == 20) btn[4:3] = 2'b00;
    end
  endtask

  task automatic test_switches();
    logic [NS-1:0] vals [2];
    logic [NS-1:0] prev;
    vals[0] = 16'hA5C3;
    vals[1] = 16'h5A3C;
    prev = '0;
    for (int i = 0; i < 2; i++) begin
      sw = vals[i];
      step();
      total++;
      if (swo !== prev) begin
        bad++;
        $display("FAIL switch_edge1 i=%0d got=%h exp=%h", i, swo, prev);
      end
      step();
      total++;
      if (swo !== vals[i]) begin
        bad++;
        $display("FAIL switch_edge2 i=%0d got=%h exp=%h", i, swo, vals[i]);
      end
      prev = vals[i];
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [NB-1:0] el, ep, er;
    btn[2] = 1'b1;
    for (int k = 1; k <= 20; k++) step();
    total++;
    if (lvl[2] !== 1'b1) begin
      bad++;
      $display("FAIL hold_before_reset got=%b exp=1", lvl[2]);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({lvl, prs, rpt, swo} !== '0) begin
      bad++;
      $display("FAIL async_reset got=%h exp=0", {lvl, prs, rpt, swo});
    end
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if ({lvl, prs, rpt} !== '0) begin
        bad++;
        $display("FAIL in_reset k=%0d got=%b/%b/%b exp=0/0/0", k, lvl, prs, rpt);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      el = '0; ep = '0; er = '0;
      el[2] = (k >= 6);
      ep[2] = (k == 6);
      er[2] = (k == 6);
      total++;
      if ({lvl, prs, rpt} !== {el, ep, er}) begin
        bad++;
        $display("FAIL post_reset k=%0d got=%b/%b/%b exp=%b/%b/%b", k, lvl, prs, rpt,
                 el, ep, er);
      end
    end
    btn[2] = 1'b0;
    for (int k = 0; k < 10; k++) step();
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_in_delay();
    test_simultaneous();
    test_switches();
    test_reset_mid_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
